// File: rtl/bcd_scan_driver.sv
`timescale 1ns/1ps
// bcd_scan_driver
//   Time-multiplexes a packed BCD value onto a common-segment 7-segment
//   display, one digit per refresh slot. The incoming value is
//   double-buffered so a new value only replaces the shown one at a frame
//   boundary, which keeps a frame from mixing old and new digits.
//
// Ports
//   clk          system clock, rising edge
//   reset_n      synchronous active-low reset
//   bcd_in       packed BCD value, digit 0 in bits [3:0] (least significant)
//   load         single-cycle strobe, captures bcd_in into the pending buffer
//   enable       1 = display on, 0 = all anodes off (scanning keeps running)
//   blank_lz     1 = blank leading zeros (digit 0 is never blanked)
//   digit_out    registered BCD nibble for the downstream segment decoder
//   anode        registered active-low digit enables
//   frame_start  one-cycle pulse, the cycle after the scan wraps to digit 0
//   invalid      sticky flag, set when a nibble > 9 reaches the output stage
module bcd_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    load,
  input  logic                    enable,
  input  logic                    blank_lz,
  output logic [3:0]              digit_out,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_start,
  output logic                    invalid
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  // Stage p0: scan timing and display buffers
  logic [CW-1:0] cnt_p0;
  logic [IW-1:0] idx_p0;
  logic [DW-1:0] disp_p0;
  logic [DW-1:0] pend_p0;
  logic          pend_vld_p0;

  logic       tick;
  logic       boundary;
  logic [3:0] nib;
  logic       upper_zero;
  logic       suppress;

  assign tick     = (cnt_p0 == CNT_LAST);
  assign boundary = tick && (idx_p0 == IDX_LAST);

  // A digit is a leading zero when it and every more-significant digit are 0.
  always_comb begin
    nib        = disp_p0[4*int'(idx_p0) +: 4];
    upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((i >= int'(idx_p0)) && (disp_p0[4*i +: 4] != 4'd0))
        upper_zero = 1'b0;
    end
    suppress = !enable || (nib > 4'd9) ||
               (blank_lz && (idx_p0 != '0) && upper_zero);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_p0      <= '0;
      idx_p0      <= '0;
      disp_p0     <= '0;
      pend_p0     <= '0;
      pend_vld_p0 <= 1'b0;
      digit_out   <= 4'd0;
      anode       <= '1;
      frame_start <= 1'b0;
      invalid     <= 1'b0;
    end else begin
      cnt_p0 <= tick ? '0 : cnt_p0 + 1'b1;
      if (tick)
        idx_p0 <= boundary ? '0 : idx_p0 + 1'b1;

      // The shown value only changes on a frame boundary; a load landing on
      // the boundary itself bypasses the pending buffer.
      if (boundary) begin
        if (load)
          disp_p0 <= bcd_in;
        else if (pend_vld_p0)
          disp_p0 <= pend_p0;
        pend_vld_p0 <= 1'b0;
      end else if (load) begin
        pend_p0     <= bcd_in;
        pend_vld_p0 <= 1'b1;
      end

      // Stage p1: registered display outputs
      digit_out   <= nib;
      anode       <= suppress ? '1 : ~(NUM_DIGITS'(1) << idx_p0);
      frame_start <= boundary;
      if (nib > 4'd9)
        invalid <= 1'b1;
    end
  end

endmodule

// File: doc/bcd_scan_driver.md
Name: bcd_scan_driver

Overview:
- Time-multiplexes a NUM_DIGITS-digit packed BCD value onto a common-segment 7-segment display.
- Selects one digit per refresh slot and presents its nibble to the downstream BCD-to-7-segment decoder.
- Drives the matching active-low anode.
- Double-buffers the incoming value so updates take effect only at frame boundaries (no tearing). Provides optional leading-zero blanking and invalid-nibble detection.

Parameters:
- NUM_DIGITS, 4, number of display digits (2..8).
- REFRESH_DIV, 100000, clk cycles per digit slot (>=2); 100 MHz / 100000 = 1 kHz per digit.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset_n  input  1  synchronous active-low reset.
- bcd_in  input  4*NUM_DIGITS  packed BCD value; digit 0 = bits [3:0] = least significant.
- load  input  1  single-cycle strobe; capture bcd_in into pending buffer.
- enable  input  1  1 = display on; 0 = all anodes off (scanning continues).
- blank_lz  input  1  1 = blank leading zeros.
- digit_out  output  4  BCD nibble to decoder (registered).
- anode  output  NUM_DIGITS  active-low digit enables (registered).
- frame_start  output  1  one-cycle pulse when the scan wraps to digit 0.
- invalid  output  1  sticky; set when a displayed nibble >9 is encountered.

Behaviour:
- Reset (reset_n=0 at a clk edge) clears all state:
  - anode = all 1s, digit_out = 0, frame_start = 0, invalid = 0.
  - refresh counter = 0, digit index = 0.
  - display register = 0, pending register = 0, pending flag = 0.
  - Reset mid-frame or mid-update discards any pending load.
- Refresh counter counts 0..REFRESH_DIV-1 and wraps. Tick = counter at REFRESH_DIV-1.
- Digit index advances on tick: 0,1,..,NUM_DIGITS-1,0. Boundary = tick while index = NUM_DIGITS-1.
- Loading:
  - load=1 copies bcd_in into pending and sets the pending flag; a later load overwrites pending.
  - At a boundary with the pending flag set: display register <= pending, flag cleared.
  - load=1 in the same cycle as a boundary: display register <= bcd_in directly, flag cleared.
  - Display is never updated mid-frame.
- frame_start is registered and asserts for exactly one cycle, the cycle after the boundary edge. It pulses every frame regardless of load.
- Output stage is registered, 1-cycle latency from index/display state:
  - digit_out = display nibble at current index.
  - anode = all 1s except bit[index] = 0, unless the digit is suppressed.
- Suppression (anode all 1s for that slot) applies when any of these hold:
  - enable = 0.
  - The nibble > 9. Also sets invalid; digit_out still carries the raw nibble.
  - blank_lz = 1, index > 0, and every nibble from index up to NUM_DIGITS-1 equals 0. Digit 0 is never zero-blanked.
- Changes to enable and blank_lz take effect on the next output register update (1 cycle). No frame-boundary wait.
- invalid is cleared only by reset.
- After reset release, the first output update shows index 0: anode = ...1110, digit_out = 0.

Test Plan:
Setup for all scenarios: NUM_DIGITS=4, REFRESH_DIV=4, enable=1 unless stated.
1. Reset, then bcd_in=16'h1234 loaded; run 2 frames -> after the first boundary, anode cycles 1110,1101,1011,0111 with digit_out 4,3,2,1. Each slot is 4 cycles. frame_start pulses once per 16 cycles.
2. Tear-free update: display shows 1234; load 16'h5678 while index=1 -> digits 2,3 of the current frame still show 2,1; the next frame shows 8,7,6,5. Load coincident with the boundary -> the next frame shows the new value immediately.
3. Leading-zero blanking: display 16'h0040, blank_lz=1 -> slots 3 and 2 have anode 1111; slot 1 shows 4; slot 0 shows 0. Display 16'h0000 -> only digit 0 lit, showing 0. Toggling blank_lz=0 lights all digits within 1 cycle.
4. Invalid nibble: display 16'h12A4 -> slot 1 anode 1111, digit_out=A, invalid rises and stays 1 after loading a valid value; reset clears it.
5. enable=0 for one frame -> anode 1111 throughout while index and frame_start keep running. Re-enable -> the correct digit lights on the next cycle.
6. Reset asserted mid-frame with a pending load -> the cycle after the edge shows anode 1111, digit_out 0, invalid 0. After release, the display shows 0000 and the pending value is never shown.
